// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver that decodes frames into scan codes, tracks
// make/break prefixes and keeps a held-state bit for a few chosen keys,
// from which two joystick-style axes are derived.
module ps2_key_tracker #(
    parameter int                      NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*8-1:0]   KEY_CODES      = {8'h23, 8'h1C, 8'h1B, 8'h1D},
    parameter int                      TIMEOUT_CYCLES = 5000,
    parameter int                      SYNC_STAGES    = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic [7:0]          code,
    output logic                code_valid,
    output logic                code_release,
    output logic                code_extended,
    output logic                frame_error,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [1:0]          up_down,
    output logic [1:0]          left_right
);

    localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic                   clk_prev_reg;
    logic                   ps2_fall;
    logic                   ps2_bit;

    state_t                 state_reg, state_next;
    logic [2:0]             bit_cnt_reg, bit_cnt_next;
    logic [7:0]             shift_reg, shift_next;
    logic                   parity_reg, parity_next;
    logic [TW-1:0]          tmo_reg, tmo_next;
    logic                   byte_good;
    logic                   frame_bad;

    logic                   rel_flag_reg;
    logic                   ext_flag_reg;
    logic [7:0]             code_reg;
    logic                   code_valid_reg;
    logic                   code_release_reg;
    logic                   code_extended_reg;
    logic                   frame_error_reg;
    logic [NUM_KEYS-1:0]    key_down_reg;
    logic [NUM_KEYS-1:0]    key_match;

    // Bring both PS/2 lines into the clock domain; MSB is the settled value.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync_reg  <= '1;
            data_sync_reg <= '1;
            clk_prev_reg  <= 1'b1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
            data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
            clk_prev_reg  <= clk_sync_reg[SYNC_STAGES-1];
        end
    end

    assign ps2_fall = clk_prev_reg & ~clk_sync_reg[SYNC_STAGES-1];
    assign ps2_bit  = data_sync_reg[SYNC_STAGES-1];

    // Frame state and bit accumulation registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            tmo_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            parity_reg  <= parity_next;
            tmo_reg     <= tmo_next;
        end
    end

    // Frame walker: one state/bit per falling edge, with an inter-edge watchdog.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        parity_next  = parity_reg;
        tmo_next     = '0;
        byte_good    = 1'b0;
        frame_bad    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (ps2_fall && !ps2_bit) begin
                    state_next   = ST_DATA;
                    bit_cnt_next = '0;
                end
            end
            ST_DATA: begin
                if (ps2_fall) begin
                    shift_next   = {ps2_bit, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (ps2_fall) begin
                    parity_next = ps2_bit;
                    state_next  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (ps2_fall) begin
                    state_next = ST_IDLE;
                    if (ps2_bit && (^{shift_reg, parity_reg})) begin
                        byte_good = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Mid-frame watchdog; an edge arriving in the expiry cycle wins.
        if (state_reg != ST_IDLE && !ps2_fall) begin
            if (tmo_reg == TMO_LAST) begin
                state_next = ST_IDLE;
                frame_bad  = 1'b1;
            end else begin
                tmo_next = tmo_reg + TW'(1);
            end
        end
    end

    // Which tracked keys the just-received byte refers to.
    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_match
            assign key_match[gi] = (KEY_CODES[8*gi +: 8] == shift_reg);
        end
    endgenerate

    // Byte interpretation: prefixes, code strobe and held-key bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            rel_flag_reg      <= 1'b0;
            ext_flag_reg      <= 1'b0;
            code_reg          <= '0;
            code_valid_reg    <= 1'b0;
            code_release_reg  <= 1'b0;
            code_extended_reg <= 1'b0;
            frame_error_reg   <= 1'b0;
            key_down_reg      <= '0;
        end else begin
            code_valid_reg  <= 1'b0;
            frame_error_reg <= 1'b0;
            if (frame_bad) begin
                frame_error_reg <= 1'b1;
                rel_flag_reg    <= 1'b0;
                ext_flag_reg    <= 1'b0;
            end else if (byte_good) begin
                if (shift_reg == 8'hE0) begin
                    ext_flag_reg <= 1'b1;
                end else if (shift_reg == 8'hF0) begin
                    rel_flag_reg <= 1'b1;
                end else begin
                    code_reg          <= shift_reg;
                    code_valid_reg    <= 1'b1;
                    code_release_reg  <= rel_flag_reg;
                    code_extended_reg <= ext_flag_reg;
                    rel_flag_reg      <= 1'b0;
                    ext_flag_reg      <= 1'b0;
                    if (!ext_flag_reg) begin
                        key_down_reg <= rel_flag_reg ? (key_down_reg & ~key_match)
                                                     : (key_down_reg | key_match);
                    end
                end
            end
        end
    end

    assign code          = code_reg;
    assign code_valid    = code_valid_reg;
    assign code_release  = code_release_reg;
    assign code_extended = code_extended_reg;
    assign frame_error   = frame_error_reg;
    assign key_down      = key_down_reg;

    // Axes: a single pressed key of a pair selects its direction, else stop.
    generate
        if (NUM_KEYS >= 4) begin : g_axes
            assign up_down    = (key_down_reg[0] && !key_down_reg[1]) ? 2'd0 :
                                (key_down_reg[1] && !key_down_reg[0]) ? 2'd1 : 2'd2;
            assign left_right = (key_down_reg[2] && !key_down_reg[3]) ? 2'd0 :
                                (key_down_reg[3] && !key_down_reg[2]) ? 2'd1 : 2'd2;
        end else begin : g_no_axes
            assign up_down    = 2'd2;
            assign left_right = 2'd2;
        end
    endgenerate

endmodule

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4: number of tracked keys, minimum 1.
REQ-002 SHALL have parameter KEY_CODES, width NUM_KEYS*8, default {8'h23,8'h1C,8'h1B,8'h1D}: per-key scan code, index i in bits [8i+7:8i], so index 0=W, 1=S, 2=A, 3=D.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 5000: maximum clock cycles between PS/2 falling edges inside a frame.
REQ-004 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth on ps2_clk and ps2_data, minimum 2.
REQ-005 SHALL have port clock, input, 1 bit: system clock; the only clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port ps2_clk, input, 1 bit: asynchronous PS/2 clock line.
REQ-008 SHALL have port ps2_data, input, 1 bit: asynchronous PS/2 data line.
REQ-009 SHALL have port code, output, 8 bits: last accepted non-prefix scan code.
REQ-010 SHALL have port code_valid, output, 1 bit: one-cycle strobe when code updates.
REQ-011 SHALL have port code_release, output, 1 bit: F0 prefix preceded code; valid with code_valid.
REQ-012 SHALL have port code_extended, output, 1 bit: E0 prefix preceded code; valid with code_valid.
REQ-013 SHALL have port frame_error, output, 1 bit: one-cycle strobe on a rejected frame.
REQ-014 SHALL have port key_down, output, NUM_KEYS bits: held state per tracked key.
REQ-015 SHALL have port up_down, output, 2 bits: 0 up, 1 down, 2 stop.
REQ-016 SHALL have port left_right, output, 2 bits: 0 left, 1 right, 2 stop.

Function
REQ-017 SHALL sample ps2_clk/ps2_data through SYNC_STAGES flops; a falling edge is synced clk previous 1, current 0; data is sampled from the synced data in that cycle.
REQ-018 SHALL use frame FSM IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE, advancing one state/bit per falling edge.
REQ-019 SHALL, in IDLE, enter DATA on an edge with data 0; edge with data 1 is ignored with no error.
REQ-020 SHALL check odd parity (8 data bits + parity bit has an odd count of ones) and stop bit = 1; either failing -> frame_error pulse, byte discarded, prefix flags cleared, return to IDLE.
REQ-021 SHALL count cycles since the last edge while not IDLE; on reaching TIMEOUT_CYCLES with no edge that cycle -> IDLE, frame_error pulse, partial byte and prefix flags discarded; an edge in the same cycle wins.
REQ-022 SHALL, on a good byte 8'hE0, set the extended flag; on 8'hF0, set the release flag; in both cases no code_valid is asserted; the flags accumulate in any order.
REQ-023 SHALL, on any other good byte, assert code_valid in the clock cycle after the stop-bit edge, with code=byte and code_release/code_extended equal to the flags, then clear both flags.
REQ-024 SHALL hold code, code_release and code_extended between strobes.
REQ-025 SHALL, in the same cycle as code_valid with code_extended=0, set key_down[i] on press or clear it on release for every i whose KEY_CODES entry equals code; extended codes never alter key_down.
REQ-026 SHALL treat typematic repeat presses of a held key, and releases of keys not held, as no change to key_down.
REQ-027 SHALL, when NUM_KEYS >= 4, drive up_down = 0 if only key_down[0] is set, 1 if only key_down[1] is set, and 2 if neither or both are set; left_right follows the same rule with key_down[2]/[3]; both are combinational from key_down.
REQ-028 SHALL hold up_down and left_right at 2 when NUM_KEYS < 4.

Reset
REQ-029 SHALL, while reset=1 at a clock edge, force FSM=IDLE, flags=0, counters=0, synchroniser flops=1, code=0, code_valid=0, code_release=0, code_extended=0, frame_error=0, key_down=0, up_down=2, left_right=2.
REQ-030 SHALL let reset take priority over all events; reset asserted mid-frame discards the partial frame without a frame_error pulse.

Verification
REQ-031 SHALL be verified by this scenario: frame 8'h1D with correct parity -> code_valid pulse, code=1D, key_down=4'b0001, up_down=0.
REQ-032 SHALL be verified by this scenario: F0 then 1D after REQ-031 -> code_release=1, key_down=0, up_down=2.
REQ-033 SHALL be verified by this scenario: 1C pressed, then 23 pressed -> left_right=2; F0 1C -> left_right=1.
REQ-034 SHALL be verified by this scenario: frame 8'h1B with inverted parity -> frame_error pulse, no code_valid, key_down unchanged.
REQ-035 SHALL be verified by this scenario: 5 bits sent, then idle for TIMEOUT_CYCLES -> frame_error pulse; the next valid 8'h23 frame decodes with key_down[3]=1.
REQ-036 SHALL be verified by this scenario: E0 F0 1D -> code_valid with code_extended=1 and code_release=1, key_down unchanged.
